// File: rtl/dma_sched.sv
// DELQA DMA job scheduler: arbitrates TX/RX jobs, programs the DMA register file as bus master,
// polls for completion. Define DMA_SCHED_WDOG_EN to add the completion watchdog.
module dma_sched #(
  parameter logic [5:0]  BUS_TMO     = 6'd63,
  parameter int unsigned POLL_GAP    = 4,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tx_req_i,
  input  logic [21:0] tx_haddr_i,
  input  logic [15:0] tx_lad_i,
  input  logic [15:0] tx_wcnt_i,
  output logic        tx_done_o,
  input  logic        rx_req_i,
  input  logic [21:0] rx_haddr_i,
  input  logic [15:0] rx_lad_i,
  input  logic [15:0] rx_wcnt_i,
  output logic        rx_done_o,
  output logic [1:0]  err_o,
  output logic        busy_o,
  output logic [2:0]  m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [1:0]  m_sel_o,
  input  logic        m_ack_i
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_IDLE   = 4'd1;
  localparam logic [3:0] S_WR_WC  = 4'd2;
  localparam logic [3:0] S_WR_LAD = 4'd3;
  localparam logic [3:0] S_WR_HLO = 4'd4;
  localparam logic [3:0] S_WR_HHI = 4'd5;
  localparam logic [3:0] S_WR_OP  = 4'd6;
  localparam logic [3:0] S_POLL   = 4'd7;
  localparam logic [3:0] S_CLR    = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;

  logic [3:0]  state_q, state_d;
  logic        prio_q, prio_d;   // 1: RX wins the next tie
  logic        dir_q, dir_d;     // 1: RX job
  logic [21:0] haddr_q, haddr_d;
  logic [15:0] lad_q, lad_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        nxm_q, nxm_d;
  logic        busy_q, busy_d;
  logic        tx_done_q, tx_done_d;
  logic        rx_done_q, rx_done_d;
  logic [1:0]  err_q, err_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [2:0]  adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [7:0]  gap_q, gap_d;

  logic        pick_rx;
  logic [21:0] sel_haddr;
  logic [15:0] sel_lad;
  logic [15:0] sel_wcnt;
  logic        bus_need;
  logic        bus_we;
  logic [2:0]  bus_adr;
  logic [15:0] bus_dat;
  logic        wd_hit;
  logic        wd_err;
  logic        unused_dat;

  assign pick_rx   = rx_req_i && (!tx_req_i || prio_q);
  assign sel_haddr = pick_rx ? rx_haddr_i : tx_haddr_i;
  assign sel_lad   = pick_rx ? rx_lad_i   : tx_lad_i;
  assign sel_wcnt  = pick_rx ? rx_wcnt_i  : tx_wcnt_i;
  assign unused_dat = ^{m_dat_i[15:8], m_dat_i[5:0]};

  always_comb begin
    bus_need = 1'b1;
    bus_we   = 1'b1;
    bus_adr  = '0;
    bus_dat  = '0;
    case (state_q)
      S_INIT:   begin bus_adr = 3'd5; bus_dat = {10'd0, BUS_TMO}; end
      S_WR_WC:  begin bus_adr = 3'd1; bus_dat = wcnt_q; end
      S_WR_LAD: begin bus_adr = 3'd2; bus_dat = lad_q; end
      S_WR_HLO: begin bus_adr = 3'd3; bus_dat = haddr_q[15:0]; end
      S_WR_HHI: begin bus_adr = 3'd4; bus_dat = {10'd0, haddr_q[21:16]}; end
      S_WR_OP:  begin bus_adr = 3'd0; bus_dat = dir_q ? 16'h0005 : 16'h000A; end
      S_POLL:   bus_we = 1'b0;
      S_CLR:    ;
      default:  bus_need = 1'b0;
    endcase
  end

`ifdef DMA_SCHED_WDOG_EN
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        wd_err_q, wd_err_d;

  assign wd_hit = (state_q == S_POLL) && !cyc_q && (wd_cnt_q >= WDOG_CYCLES);
  assign wd_err = wd_err_q;

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == S_POLL)
      wd_cnt_d = (wd_cnt_q < WDOG_CYCLES) ? wd_cnt_q + 32'd1 : wd_cnt_q;
    wd_err_d = wd_err_q;
    if (state_q == S_IDLE)
      wd_err_d = 1'b0;
    else if (wd_hit)
      wd_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    dir_d     = dir_q;
    haddr_d   = haddr_q;
    lad_d     = lad_q;
    wcnt_d    = wcnt_q;
    nxm_d     = nxm_q;
    busy_d    = busy_q;
    tx_done_d = 1'b0;
    rx_done_d = 1'b0;
    err_d     = '0;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    gap_d     = gap_q;

    case (state_q)
      S_IDLE: begin
        if (tx_req_i || rx_req_i) begin
          dir_d   = pick_rx;
          haddr_d = sel_haddr;
          lad_d   = sel_lad;
          wcnt_d  = sel_wcnt;
          nxm_d   = 1'b0;
          if (sel_wcnt == '0) begin
            // Empty job: report immediately, never touches the DMA engine
            state_d   = S_DONE;
            tx_done_d = !pick_rx;
            rx_done_d = pick_rx;
            prio_d    = !pick_rx;
          end else begin
            state_d = S_WR_WC;
            busy_d  = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: ;
    endcase

    if (bus_need) begin
      if (cyc_q) begin
        if (m_ack_i) begin
          cyc_d = 1'b0;
          we_d  = 1'b0;
          adr_d = '0;
          dat_d = '0;
          case (state_q)
            S_INIT:   state_d = S_IDLE;
            S_WR_WC:  state_d = S_WR_LAD;
            S_WR_LAD: state_d = S_WR_HLO;
            S_WR_HLO: state_d = S_WR_HHI;
            S_WR_HHI: state_d = S_WR_OP;
            S_WR_OP: begin
              state_d = S_POLL;
              gap_d   = '0;
            end
            S_POLL: begin
              if (m_dat_i[7]) begin
                nxm_d   = m_dat_i[6];
                state_d = S_CLR;
              end else begin
                gap_d = 8'(POLL_GAP);
              end
            end
            S_CLR: begin
              state_d   = S_DONE;
              busy_d    = 1'b0;
              tx_done_d = !dir_q;
              rx_done_d = dir_q;
              err_d     = {wd_err, nxm_q};
              prio_d    = !dir_q;
            end
            default: ;
          endcase
        end
      end else if (wd_hit) begin
        state_d = S_CLR;
        nxm_d   = 1'b0;
      end else if (gap_q != '0) begin
        gap_d = gap_q - 8'd1;
      end else begin
        cyc_d = 1'b1;
        we_d  = bus_we;
        adr_d = bus_adr;
        dat_d = bus_dat;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_INIT;
      prio_q    <= 1'b0;
      dir_q     <= 1'b0;
      haddr_q   <= '0;
      lad_q     <= '0;
      wcnt_q    <= '0;
      nxm_q     <= 1'b0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      err_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      dir_q     <= dir_d;
      haddr_q   <= haddr_d;
      lad_q     <= lad_d;
      wcnt_q    <= wcnt_d;
      nxm_q     <= nxm_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      gap_q     <= gap_d;
    end
  end

  assign tx_done_o = tx_done_q;
  assign rx_done_o = rx_done_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;
  assign m_cyc_o   = cyc_q;
  assign m_stb_o   = cyc_q;
  assign m_we_o    = we_q;
  assign m_adr_o   = adr_q;
  assign m_dat_o   = dat_q;
  assign m_sel_o   = 2'b11;

endmodule

// File: tb/tb_dma_sched.sv
// Scoreboard bench for dma_sched: a DMA register-file model acks bus cycles, while
// monitors compare bus writes and done pulses against queued expectations.
module tb_dma_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_req, rx_req;
  logic [21:0] tx_haddr, rx_haddr;
  logic [15:0] tx_lad, rx_lad, tx_wcnt, rx_wcnt;
  logic        tx_done, rx_done, busy;
  logic [1:0]  err, m_sel;
  logic [2:0]  m_adr;
  logic [15:0] m_dat_o, m_dat_i;
  logic        m_cyc, m_stb, m_we, m_ack;

  always #5 clk = ~clk;

  dma_sched #(.BUS_TMO(6'd63), .POLL_GAP(4), .WDOG_CYCLES(100)) dut (
    .clk_i(clk), .rst_i(rst),
    .tx_req_i(tx_req), .tx_haddr_i(tx_haddr), .tx_lad_i(tx_lad), .tx_wcnt_i(tx_wcnt),
    .tx_done_o(tx_done),
    .rx_req_i(rx_req), .rx_haddr_i(rx_haddr), .rx_lad_i(rx_lad), .rx_wcnt_i(rx_wcnt),
    .rx_done_o(rx_done),
    .err_o(err), .busy_o(busy),
    .m_adr_o(m_adr), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
    .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel), .m_ack_i(m_ack)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [18:0] wr_q[$];     // {adr, data}
  logic [3:0]  done_q[$];   // {tx_done, rx_done, err}
  int          txn_cnt = 0;
  int          cfg_polls = 2;
  logic [15:0] cfg_status = 16'h0080;
  int          polls_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexp(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0h, nothing expected", name, act);
  endtask

  task automatic wr(input logic [2:0] adr, input logic [15:0] dat);
    wr_q.push_back({adr, dat});
  endtask

  task automatic push_job(input logic [15:0] op, input logic [15:0] wc, input logic [15:0] lad,
                          input logic [15:0] hlo, input logic [15:0] hhi,
                          input bit finish, input logic [3:0] dn);
    wr(3'd1, wc); wr(3'd2, lad); wr(3'd3, hlo); wr(3'd4, hhi); wr(3'd0, op);
    if (finish) begin
      wr(3'd0, 16'h0000);
      done_q.push_back(dn);
    end
  endtask

  task automatic wait_done(input bit rx, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (rx ? rx_done : tx_done) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_wr_empty(input string name);
    for (int i = 0; i < 3000 && wr_q.size() != 0; i++) @(negedge clk);
    check(name, wr_q.size(), 32'd0);
  endtask

  // DMA register-file model: acks one clock after the strobe, answers status reads
  always @(negedge clk) begin
    if (m_cyc && !m_ack) begin
      txn_cnt++;
      check("stb_sel", {29'd0, m_stb, m_sel}, 32'h7);
      if (m_we) begin
        if (wr_q.size() == 0) fail_unexp("bus_wr_unexp", {13'd0, m_adr, m_dat_o});
        else check("bus_wr", {13'd0, m_adr, m_dat_o}, {13'd0, wr_q.pop_front()});
        if (m_adr == 3'd0 && m_dat_o != 16'h0000) polls_left = cfg_polls;
        m_dat_i = '0;
      end else begin
        check("rd_adr", {29'd0, m_adr}, 32'd0);
        if (polls_left == 0) m_dat_i = cfg_status;
        else begin
          m_dat_i = '0;
          polls_left--;
        end
      end
      m_ack = 1'b1;
    end else if (!m_cyc) begin
      m_ack = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_done || rx_done) begin
      if (done_q.size() == 0) fail_unexp("done_unexp", {28'd0, tx_done, rx_done, err});
      else check("done", {28'd0, tx_done, rx_done, err}, {28'd0, done_q.pop_front()});
      check("busy_at_done", {31'd0, busy}, 32'd0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bit seen;
    rst = 1'b1; tx_req = 1'b0; rx_req = 1'b0; m_ack = 1'b0; m_dat_i = '0;
    tx_haddr = '0; tx_lad = '0; tx_wcnt = '0; rx_haddr = '0; rx_lad = '0; rx_wcnt = '0;
    repeat (3) @(negedge clk);
    check("rst_out", {busy, tx_done, rx_done, err, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 32'd0);
    check("rst_sel", {30'd0, m_sel}, 32'd3);

    // INIT: single timeout write, then a quiet bus
    wr(3'd5, 16'h003F);
    rst = 1'b0;
    wait_wr_empty("init_wr");
    t = txn_cnt;
    repeat (10) @(negedge clk);
    check("idle_bus", txn_cnt, t);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // First tie after reset -> TX, then RX; TX re-requests while RX pending -> RX first
    tx_haddr = 22'h3ABCDE; tx_lad = 16'h1234; tx_wcnt = 16'hFFF0;
    rx_haddr = 22'h000100; rx_lad = 16'h0200; rx_wcnt = 16'hFFFF;
    push_job(16'h000A, 16'hFFF0, 16'h1234, 16'hBCDE, 16'h003A, 1'b1, 4'b1000);
    push_job(16'h0005, 16'hFFFF, 16'h0200, 16'h0100, 16'h0000, 1'b1, 4'b0100);
    push_job(16'h000A, 16'h8000, 16'hFFFE, 16'hFFFE, 16'h002F, 1'b1, 4'b1000);
    tx_req = 1'b1; rx_req = 1'b1;
    wait_done(1'b0, "tie_tx1");
    tx_req = 1'b0;
    @(negedge clk);
    tx_haddr = 22'h2FFFFE; tx_lad = 16'hFFFE; tx_wcnt = 16'h8000;
    tx_req = 1'b1;
    wait_done(1'b1, "tie_rx1");
    rx_req = 1'b0;
    wait_done(1'b0, "tie_tx2");
    tx_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reference TX job
    tx_haddr = 22'h012340; tx_lad = 16'h0800; tx_wcnt = 16'hFFFC;
    push_job(16'h000A, 16'hFFFC, 16'h0800, 16'h2340, 16'h0001, 1'b1, 4'b1000);
    tx_req = 1'b1;
    @(negedge clk);
    check("busy_job", {31'd0, busy}, 32'd1);
    wait_done(1'b0, "tx_done");
    tx_req = 1'b0;
    repeat (2) @(negedge clk);

    // RX job reporting a non-existent-memory error
    cfg_status = 16'h00C0;
    rx_haddr = 22'h1F0002; rx_lad = 16'h0040; rx_wcnt = 16'hFFFE;
    push_job(16'h0005, 16'hFFFE, 16'h0040, 16'h0002, 16'h001F, 1'b1, 4'b0101);
    rx_req = 1'b1;
    wait_done(1'b1, "rx_nxm");
    rx_req = 1'b0;
    cfg_status = 16'h0080;
    repeat (2) @(negedge clk);

    // Zero word count: done within 3 clocks, no bus cycles
    t = txn_cnt;
    tx_wcnt = 16'h0000;
    done_q.push_back(4'b1000);
    tx_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    check("wc0_latency", {31'd0, seen}, 32'd1);
    tx_req = 1'b0;
    repeat (4) @(negedge clk);
    check("wc0_nobus", txn_cnt, t);

    // Reset while polling a job that never completes
    cfg_polls = 100000;
    rx_haddr = 22'h000800; rx_lad = 16'h0000; rx_wcnt = 16'hFFFF;
    push_job(16'h0005, 16'hFFFF, 16'h0000, 16'h0800, 16'h0000, 1'b0, 4'b0000);
    rx_req = 1'b1;
    wait_wr_empty("rst_job_wr");
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_out", {busy, tx_done, rx_done, err, m_cyc, m_stb, m_we, m_adr, m_dat_o}, 32'd0);
    rx_req = 1'b0;
    repeat (3) @(negedge clk);
    polls_left = 0;
    cfg_polls = 2;
    wr(3'd5, 16'h003F);
    rst = 1'b0;
    wait_wr_empty("reinit_wr");
    repeat (2) @(negedge clk);

    // Priority pointer back to TX after reset (last finished job before it was TX-preferred-loser)
    tx_haddr = 22'h000002; tx_lad = 16'h0004; tx_wcnt = 16'hFFFF;
    rx_haddr = 22'h3FFFFF; rx_lad = 16'h0006; rx_wcnt = 16'hFFFD;
    push_job(16'h000A, 16'hFFFF, 16'h0004, 16'h0002, 16'h0000, 1'b1, 4'b1000);
    push_job(16'h0005, 16'hFFFD, 16'h0006, 16'hFFFF, 16'h003F, 1'b1, 4'b0100);
    tx_req = 1'b1; rx_req = 1'b1;
    wait_done(1'b0, "post_rst_tx");
    tx_req = 1'b0;
    wait_done(1'b1, "post_rst_rx");
    rx_req = 1'b0;
    repeat (2) @(negedge clk);

`ifdef DMA_SCHED_WDOG_EN
    // Completion never signalled: watchdog clears the op and flags err[1]
    cfg_polls = 100000;
    tx_haddr = 22'h000020; tx_lad = 16'h0010; tx_wcnt = 16'hFFFF;
    push_job(16'h000A, 16'hFFFF, 16'h0010, 16'h0020, 16'h0000, 1'b1, 4'b1010);
    tx_req = 1'b1;
    wait_done(1'b0, "wdog_done");
    tx_req = 1'b0;
    cfg_polls = 2;
    repeat (2) @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
